tablero_controller: RTL and testbench
=====================================

TABLERO_CONTROLLER -- requirements
Module: tablero_controller

Interface
REQ-001 Parameters, each name / default / meaning: MAR / 3'b000 / unshot cell; D_FALLIDO / 3'b001 / miss; B_DESTRUIDO / 3'b010 / sunk fleet cell; D_ACERTADO / 3'b011 / hit; SELECTED / 3'b100 / cursor overlay.
REQ-002 clk  input  1  system clock; single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 cargar  input  1  one-cycle pulse; latches both ship maps and starts a game.
REQ-005 barcos_jugador  input  [4:0][4:0] x1  player ship map, 1 = ship.
REQ-006 barcos_pc  input  [4:0][4:0] x1  PC ship map.
REQ-007 mov_arriba, mov_abajo, mov_izq, mov_der  input  1 each  one-cycle cursor move pulses.
REQ-008 disparo  input  1  one-cycle pulse; player fires at the cursor cell on the PC board.
REQ-009 pc_valid  input  1  PC shot request.
REQ-010 pc_fila, pc_columna  input  3 each  PC shot target on the player board.
REQ-011 jugador_tablero  output  [4:0][4:0] x3  player board state codes.
REQ-012 PC_tablero  output  [4:0][4:0] x3  PC board state codes, including the cursor overlay.
REQ-013 cursor_fila, cursor_columna  output  3 each  cursor position.
REQ-014 turno  output  1  0 = player, 1 = PC.
REQ-015 disparo_ack  output  1  one-cycle pulse when a shot is accepted.
REQ-016 game_over  output  1  game finished.
REQ-017 ganador  output  1  0 = player, 1 = PC; valid only while game_over = 1.

Function
REQ-018 State machine:
- States: IDLE, TURNO_JUGADOR, TURNO_PC, FIN.
- Next state is registered; all outputs come from registers, except the overlay in REQ-020.
REQ-019 IDLE:
- All cells are MAR.
- cargar latches both maps, loads each remaining-ship counter (5-bit, 0..25) with its map's popcount, and moves to TURNO_JUGADOR.
REQ-020 Cursor overlay:
- PC_tablero[cursor_fila][cursor_columna] shows SELECTED when the stored code is MAR, in TURNO_JUGADOR only.
- Otherwise the stored code is shown.
- jugador_tablero never shows the overlay.
REQ-021 Cursor moves:
- Moves are accepted in TURNO_JUGADOR only.
- Moves saturate at 0 and 4; no wrap-around.
- Simultaneous pulses: arriba > abajo > izq > der; only one move per cycle.
REQ-022 Player shot (TURNO_JUGADOR, disparo = 1):
- If the target cell is MAR: cell becomes D_ACERTADO if it is a ship, else D_FALLIDO.
- disparo_ack pulses and the state moves to TURNO_PC.
- The update is visible on the next edge.
REQ-023 A shot at a non-MAR cell is ignored: no ack, no turn change.
REQ-024 disparo and a move in the same cycle: the shot uses the pre-move cursor and the move is discarded.
REQ-025 PC shot (TURNO_PC, pc_valid = 1) follows the same rules on jugador_tablero, then moves to TURNO_JUGADOR.
REQ-026 pc_fila > 4 or pc_columna > 4 is ignored.
REQ-027 Hit bookkeeping:
- Each hit decrements that board's counter.
- When the counter reaches 0, every D_ACERTADO cell on that board becomes B_DESTRUIDO in the same cycle.
- The state moves to FIN with game_over = 1; ganador is the shooter.
REQ-028 If a board's popcount is 0 at cargar, the state goes directly to FIN:
- Player map empty: ganador = 1.
- Else PC map empty: ganador = 0.
REQ-029 FIN:
- Boards are frozen; all shots and moves are ignored.
- cargar clears both boards to MAR and restarts as in REQ-019.
REQ-030 cargar outside IDLE and FIN is ignored.
REQ-031 Inputs are ignored in states where they have no defined effect.

Reset
REQ-032 rst_n = 0 immediately forces, independent of clk:
- state IDLE; all cells MAR;
- cursor (0,0);
- turno = 0, disparo_ack = 0, game_over = 0, ganador = 0;
- both counters = 0.
REQ-033 Reset mid-game discards all progress; latched maps are not retained.

Verification
REQ-034 Bench shall cover the following directed scenarios:
- Reset, then cargar with one ship per board at (0,0) -> TURNO_JUGADOR; PC_tablero[0][0] = SELECTED; turno = 0.
- Player disparo at (0,0) on a ship -> next cycle: cell = B_DESTRUIDO, game_over = 1, ganador = 0, disparo_ack high for 1 cycle.
- Cursor at (4,4), mov_abajo then mov_der -> stays (4,4); mov_arriba + mov_izq together -> (3,4).
- Player misses at (2,3), then PC pc_valid (5,1) -> ignored, turno stays 1; PC (1,1) on a ship -> D_ACERTADO, turno = 0.
- Player disparo again at (2,3), now D_FALLIDO -> no ack, turno stays 0, board unchanged.
- rst_n low mid-TURNO_PC -> all cells MAR, cursor (0,0), state IDLE asynchronously, before the next clk edge.

Source files
------------

// File: rtl/tablero_controller.sv
// Two-board battleship game controller: latches both fleets, alternates player/PC shots,
// tracks remaining ship cells per board and declares the winner when a fleet is sunk.
module tablero_controller #(
  parameter logic [2:0] MAR         = 3'b000,
  parameter logic [2:0] D_FALLIDO   = 3'b001,
  parameter logic [2:0] B_DESTRUIDO = 3'b010,
  parameter logic [2:0] D_ACERTADO  = 3'b011,
  parameter logic [2:0] SELECTED    = 3'b100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cargar,
  input  logic [4:0][4:0]       barcos_jugador,
  input  logic [4:0][4:0]       barcos_pc,
  input  logic                  mov_arriba,
  input  logic                  mov_abajo,
  input  logic                  mov_izq,
  input  logic                  mov_der,
  input  logic                  disparo,
  input  logic                  pc_valid,
  input  logic [2:0]            pc_fila,
  input  logic [2:0]            pc_columna,
  output logic [4:0][4:0][2:0]  jugador_tablero,
  output logic [4:0][4:0][2:0]  PC_tablero,
  output logic [2:0]            cursor_fila,
  output logic [2:0]            cursor_columna,
  output logic                  turno,
  output logic                  disparo_ack,
  output logic                  game_over,
  output logic                  ganador
);

  typedef enum logic [1:0] {IDLE, TURNO_JUGADOR, TURNO_PC, FIN} state_t;

  state_t               state, state_nx;
  logic [4:0][4:0][2:0] tab_j, tab_j_nx, tab_p, tab_p_nx;
  logic [4:0][4:0]      mapa_j, mapa_j_nx, mapa_p, mapa_p_nx;
  logic [4:0]           cnt_j, cnt_j_nx, cnt_p, cnt_p_nx;
  logic [2:0]           cur_f, cur_f_nx, cur_c, cur_c_nx;
  logic                 turno_nx, ack_nx, game_over_nx, ganador_nx;
  logic [4:0]           pop_j, pop_p;

  function automatic logic [4:0] popcount(input logic [4:0][4:0] m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        n = n + {4'b0000, m[i][j]};
    return n;
  endfunction

  // Once the last ship cell is hit, every hit on that board is shown as sunk.
  function automatic logic [4:0][4:0][2:0] hundir(input logic [4:0][4:0][2:0] t);
    logic [4:0][4:0][2:0] r;
    r = t;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (t[i][j] == D_ACERTADO) r[i][j] = B_DESTRUIDO;
    return r;
  endfunction

  assign pop_j = popcount(barcos_jugador);
  assign pop_p = popcount(barcos_pc);

  always_comb begin
    state_nx     = state;
    tab_j_nx     = tab_j;
    tab_p_nx     = tab_p;
    mapa_j_nx    = mapa_j;
    mapa_p_nx    = mapa_p;
    cnt_j_nx     = cnt_j;
    cnt_p_nx     = cnt_p;
    cur_f_nx     = cur_f;
    cur_c_nx     = cur_c;
    turno_nx     = turno;
    ack_nx       = 1'b0;
    game_over_nx = game_over;
    ganador_nx   = ganador;
    case (state)
      IDLE, FIN: begin
        if (cargar) begin
          mapa_j_nx    = barcos_jugador;
          mapa_p_nx    = barcos_pc;
          cnt_j_nx     = pop_j;
          cnt_p_nx     = pop_p;
          tab_j_nx     = '0;
          tab_p_nx     = '0;
          cur_f_nx     = 3'd0;
          cur_c_nx     = 3'd0;
          turno_nx     = 1'b0;
          game_over_nx = 1'b0;
          ganador_nx   = 1'b0;
          state_nx     = TURNO_JUGADOR;
          if (pop_j == 5'd0) begin
            state_nx     = FIN;
            game_over_nx = 1'b1;
            ganador_nx   = 1'b1;
          end else if (pop_p == 5'd0) begin
            state_nx     = FIN;
            game_over_nx = 1'b1;
          end
        end
      end
      TURNO_JUGADOR: begin
        // A fire pulse always wins over a move pulse in the same cycle.
        if (disparo) begin
          if (tab_p[cur_f][cur_c] == MAR) begin
            ack_nx   = 1'b1;
            state_nx = TURNO_PC;
            turno_nx = 1'b1;
            if (mapa_p[cur_f][cur_c]) begin
              tab_p_nx[cur_f][cur_c] = D_ACERTADO;
              cnt_p_nx               = cnt_p - 5'd1;
              if (cnt_p == 5'd1) begin
                tab_p_nx     = hundir(tab_p_nx);
                state_nx     = FIN;
                turno_nx     = 1'b0;
                game_over_nx = 1'b1;
                ganador_nx   = 1'b0;
              end
            end else begin
              tab_p_nx[cur_f][cur_c] = D_FALLIDO;
            end
          end
        end else if (mov_arriba) begin
          if (cur_f != 3'd0) cur_f_nx = cur_f - 3'd1;
        end else if (mov_abajo) begin
          if (cur_f != 3'd4) cur_f_nx = cur_f + 3'd1;
        end else if (mov_izq) begin
          if (cur_c != 3'd0) cur_c_nx = cur_c - 3'd1;
        end else if (mov_der) begin
          if (cur_c != 3'd4) cur_c_nx = cur_c + 3'd1;
        end
      end
      TURNO_PC: begin
        if (pc_valid && (pc_fila <= 3'd4) && (pc_columna <= 3'd4) &&
            (tab_j[pc_fila][pc_columna] == MAR)) begin
          ack_nx   = 1'b1;
          state_nx = TURNO_JUGADOR;
          turno_nx = 1'b0;
          if (mapa_j[pc_fila][pc_columna]) begin
            tab_j_nx[pc_fila][pc_columna] = D_ACERTADO;
            cnt_j_nx                      = cnt_j - 5'd1;
            if (cnt_j == 5'd1) begin
              tab_j_nx     = hundir(tab_j_nx);
              state_nx     = FIN;
              turno_nx     = 1'b1;
              game_over_nx = 1'b1;
              ganador_nx   = 1'b1;
            end
          end else begin
            tab_j_nx[pc_fila][pc_columna] = D_FALLIDO;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tab_j       <= '0;
      tab_p       <= '0;
      mapa_j      <= '0;
      mapa_p      <= '0;
      cnt_j       <= '0;
      cnt_p       <= '0;
      cur_f       <= '0;
      cur_c       <= '0;
      turno       <= 1'b0;
      disparo_ack <= 1'b0;
      game_over   <= 1'b0;
      ganador     <= 1'b0;
    end else begin
      state       <= state_nx;
      tab_j       <= tab_j_nx;
      tab_p       <= tab_p_nx;
      mapa_j      <= mapa_j_nx;
      mapa_p      <= mapa_p_nx;
      cnt_j       <= cnt_j_nx;
      cnt_p       <= cnt_p_nx;
      cur_f       <= cur_f_nx;
      cur_c       <= cur_c_nx;
      turno       <= turno_nx;
      disparo_ack <= ack_nx;
      game_over   <= game_over_nx;
      ganador     <= ganador_nx;
    end
  end

  // Cursor highlight is combinational so it tracks the cursor without an extra cycle.
  always_comb begin
    PC_tablero = tab_p;
    if ((state == TURNO_JUGADOR) && (tab_p[cur_f][cur_c] == MAR))
      PC_tablero[cur_f][cur_c] = SELECTED;
  end

  assign jugador_tablero = tab_j;
  assign cursor_fila     = cur_f;
  assign cursor_columna  = cur_c;

endmodule

// File: tb/tb_tablero_controller.sv
// Directed bench for tablero_controller: load, sink, cursor saturation, shots, async reset.
module tb_tablero_controller;

  localparam logic [2:0] MAR = 3'b000, D_FALLIDO = 3'b001, B_DESTRUIDO = 3'b010,
                         D_ACERTADO = 3'b011, SELECTED = 3'b100;

  logic                 clk, rst_n, cargar;
  logic [4:0][4:0]      barcos_jugador, barcos_pc;
  logic                 mov_arriba, mov_abajo, mov_izq, mov_der, disparo, pc_valid;
  logic [2:0]           pc_fila, pc_columna;
  logic [4:0][4:0][2:0] jugador_tablero, PC_tablero;
  logic [2:0]           cursor_fila, cursor_columna;
  logic                 turno, disparo_ack, game_over, ganador;

  int tests_run = 0;
  int tests_failed = 0;

  tablero_controller dut (
    .clk(clk), .rst_n(rst_n), .cargar(cargar),
    .barcos_jugador(barcos_jugador), .barcos_pc(barcos_pc),
    .mov_arriba(mov_arriba), .mov_abajo(mov_abajo), .mov_izq(mov_izq), .mov_der(mov_der),
    .disparo(disparo), .pc_valid(pc_valid), .pc_fila(pc_fila), .pc_columna(pc_columna),
    .jugador_tablero(jugador_tablero), .PC_tablero(PC_tablero),
    .cursor_fila(cursor_fila), .cursor_columna(cursor_columna),
    .turno(turno), .disparo_ack(disparo_ack), .game_over(game_over), .ganador(ganador)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cargar = 0; mov_arriba = 0; mov_abajo = 0; mov_izq = 0; mov_der = 0;
    disparo = 0; pc_valid = 0; pc_fila = 0; pc_columna = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    barcos_jugador = '0; barcos_pc = '0;
    rst_n = 0;
    tick(); tick();
    #2 rst_n = 1;
    tick();
    tests_run++;
    if ({turno, disparo_ack, game_over, ganador} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_flags got %b want 0000", {turno, disparo_ack, game_over, ganador});
    end
    tests_run++;
    if ({cursor_fila, cursor_columna} !== 6'd0 || PC_tablero !== '0 || jugador_tablero !== '0) begin
      tests_failed++; $display("FAIL reset_boards cursor %0d,%0d pc %h jug %h want 0,0 all MAR",
                               cursor_fila, cursor_columna, PC_tablero, jugador_tablero);
    end
    // Fire while in IDLE: nothing should happen.
    disparo = 1; tick(); disparo = 0;
    tests_run++;
    if (disparo_ack !== 1'b0 || PC_tablero !== '0) begin
      tests_failed++; $display("FAIL idle_ignore ack %b pc %h want 0 and all MAR", disparo_ack, PC_tablero);
    end
  endtask

  task automatic test_load();
    barcos_jugador = '0; barcos_pc = '0;
    barcos_jugador[0][0] = 1'b1; barcos_pc[0][0] = 1'b1;
    cargar = 1; tick(); cargar = 0;
    tests_run++;
    if (PC_tablero[0][0] !== SELECTED || turno !== 1'b0 || game_over !== 1'b0) begin
      tests_failed++; $display("FAIL load pc00 %0d turno %b go %b want 4 0 0", PC_tablero[0][0], turno, game_over);
    end
    tests_run++;
    if (jugador_tablero[0][0] !== MAR) begin
      tests_failed++; $display("FAIL load_no_overlay jug00 %0d want 0", jugador_tablero[0][0]);
    end
  endtask

  task automatic test_sink();
    disparo = 1; tick(); disparo = 0;
    tests_run++;
    if (PC_tablero[0][0] !== B_DESTRUIDO || game_over !== 1'b1 || ganador !== 1'b0 || disparo_ack !== 1'b1) begin
      tests_failed++; $display("FAIL sink pc00 %0d go %b gan %b ack %b want 2 1 0 1",
                               PC_tablero[0][0], game_over, ganador, disparo_ack);
    end
    tick();
    tests_run++;
    if (disparo_ack !== 1'b0) begin
      tests_failed++; $display("FAIL sink_ack_pulse ack %b want 0", disparo_ack);
    end
    // Frozen in FIN: moves and shots ignored.
    mov_der = 1; tick(); mov_der = 0;
    disparo = 1; pc_valid = 1; pc_fila = 0; pc_columna = 0; tick(); clear_inputs();
    tests_run++;
    if (cursor_columna !== 3'd0 || disparo_ack !== 1'b0 || jugador_tablero[0][0] !== MAR || game_over !== 1'b1) begin
      tests_failed++; $display("FAIL fin_frozen col %0d ack %b jug00 %0d go %b want 0 0 0 1",
                               cursor_columna, disparo_ack, jugador_tablero[0][0], game_over);
    end
  endtask

  task automatic test_cursor();
    barcos_jugador = '0; barcos_pc = '0;
    barcos_jugador[1][1] = 1'b1; barcos_jugador[3][3] = 1'b1;
    barcos_pc[0][0] = 1'b1; barcos_pc[4][4] = 1'b1;
    cargar = 1; tick(); cargar = 0;
    tests_run++;
    if (PC_tablero[0][0] !== SELECTED || game_over !== 1'b0) begin
      tests_failed++; $display("FAIL reload pc00 %0d go %b want 4 0", PC_tablero[0][0], game_over);
    end
    for (int k = 0; k < 4; k++) begin mov_abajo = 1; tick(); mov_abajo = 0; end
    for (int k = 0; k < 4; k++) begin mov_der = 1; tick(); mov_der = 0; end
    mov_abajo = 1; tick(); mov_abajo = 0;
    mov_der = 1; tick(); mov_der = 0;
    tests_run++;
    if (cursor_fila !== 3'd4 || cursor_columna !== 3'd4) begin
      tests_failed++; $display("FAIL cursor_sat got %0d,%0d want 4,4", cursor_fila, cursor_columna);
    end
    mov_arriba = 1; mov_izq = 1; tick(); clear_inputs();
    tests_run++;
    if (cursor_fila !== 3'd3 || cursor_columna !== 3'd4) begin
      tests_failed++; $display("FAIL cursor_prio got %0d,%0d want 3,4", cursor_fila, cursor_columna);
    end
    tests_run++;
    if (PC_tablero[3][4] !== SELECTED || PC_tablero[0][0] !== MAR) begin
      tests_failed++; $display("FAIL overlay_move pc34 %0d pc00 %0d want 4 0", PC_tablero[3][4], PC_tablero[0][0]);
    end
  endtask

  task automatic test_shots();
    mov_arriba = 1; tick(); mov_arriba = 0;
    mov_izq = 1; tick(); mov_izq = 0;
    disparo = 1; tick(); disparo = 0;
    tests_run++;
    if (PC_tablero[2][3] !== D_FALLIDO || disparo_ack !== 1'b1 || turno !== 1'b1) begin
      tests_failed++; $display("FAIL player_miss pc23 %0d ack %b turno %b want 1 1 1",
                               PC_tablero[2][3], disparo_ack, turno);
    end
    pc_valid = 1; pc_fila = 3'd5; pc_columna = 3'd1; tick(); clear_inputs();
    tests_run++;
    if (turno !== 1'b1 || disparo_ack !== 1'b0 || jugador_tablero !== '0) begin
      tests_failed++; $display("FAIL pc_out_of_range turno %b ack %b jug %h want 1 0 all MAR",
                               turno, disparo_ack, jugador_tablero);
    end
    pc_valid = 1; pc_fila = 3'd1; pc_columna = 3'd1; tick(); clear_inputs();
    tests_run++;
    if (jugador_tablero[1][1] !== D_ACERTADO || turno !== 1'b0 || disparo_ack !== 1'b1 || game_over !== 1'b0) begin
      tests_failed++; $display("FAIL pc_hit jug11 %0d turno %b ack %b go %b want 3 0 1 0",
                               jugador_tablero[1][1], turno, disparo_ack, game_over);
    end
  endtask

  task automatic test_repeat_shot();
    disparo = 1; tick(); disparo = 0;
    tests_run++;
    if (disparo_ack !== 1'b0 || turno !== 1'b0 || PC_tablero[2][3] !== D_FALLIDO || PC_tablero[0][0] !== MAR) begin
      tests_failed++; $display("FAIL repeat_shot ack %b turno %b pc23 %0d pc00 %0d want 0 0 1 0",
                               disparo_ack, turno, PC_tablero[2][3], PC_tablero[0][0]);
    end
  endtask

  task automatic test_fire_and_move();
    mov_arriba = 1; tick(); tick(); mov_arriba = 0;
    mov_izq = 1; tick(); tick(); tick(); mov_izq = 0;
    disparo = 1; mov_der = 1; tick(); clear_inputs();
    tests_run++;
    if (PC_tablero[0][0] !== D_ACERTADO || cursor_columna !== 3'd0 || turno !== 1'b1 || game_over !== 1'b0) begin
      tests_failed++; $display("FAIL fire_and_move pc00 %0d col %0d turno %b go %b want 3 0 1 0",
                               PC_tablero[0][0], cursor_columna, turno, game_over);
    end
  endtask

  task automatic test_async_reset();
    #3 rst_n = 0;
    #1;
    tests_run++;
    if (PC_tablero !== '0 || jugador_tablero !== '0 || cursor_fila !== 3'd0 || cursor_columna !== 3'd0) begin
      tests_failed++; $display("FAIL async_reset_boards pc %h jug %h cursor %0d,%0d want all MAR 0,0",
                               PC_tablero, jugador_tablero, cursor_fila, cursor_columna);
    end
    tests_run++;
    if ({turno, disparo_ack, game_over, ganador} !== 4'b0000) begin
      tests_failed++; $display("FAIL async_reset_flags got %b want 0000", {turno, disparo_ack, game_over, ganador});
    end
    tick();
    #2 rst_n = 1;
    pc_valid = 1; pc_fila = 3'd3; pc_columna = 3'd3; tick(); clear_inputs();
    tests_run++;
    if (disparo_ack !== 1'b0 || jugador_tablero !== '0) begin
      tests_failed++; $display("FAIL reset_to_idle ack %b jug %h want 0 all MAR", disparo_ack, jugador_tablero);
    end
  endtask

  task automatic test_empty_maps();
    barcos_jugador = '0; barcos_pc = '1;
    cargar = 1; tick(); cargar = 0;
    tests_run++;
    if (game_over !== 1'b1 || ganador !== 1'b1) begin
      tests_failed++; $display("FAIL empty_player go %b gan %b want 1 1", game_over, ganador);
    end
    barcos_jugador = '1; barcos_pc = '0;
    cargar = 1; tick(); cargar = 0;
    tests_run++;
    if (game_over !== 1'b1 || ganador !== 1'b0 || PC_tablero[0][0] !== MAR) begin
      tests_failed++; $display("FAIL empty_pc go %b gan %b pc00 %0d want 1 0 0", game_over, ganador, PC_tablero[0][0]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_sink();
    test_cursor();
    test_shots();
    test_repeat_shot();
    test_fire_and_move();
    test_async_reset();
    test_empty_maps();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
